mmcm_reconfig_ctrl: RTL and testbench

Sequencer for the board MMCME3 that generates clk_out from the 300 MHz differential oscillator. Brings the MMCM up after reset. Accepts runtime requests to change the CLKOUT0 integer divide and performs the MMCM reset + DRP read-modify-write + relock sequence. Reports lock status and completion/error. Runs on the free-running oscillator clock (osc_300 domain).

---
 rtl/mmcm_reconfig_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_mmcm_reconfig_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmcm_reconfig_ctrl.sv
// MMCME3 bring-up and runtime CLKOUT0 divide reconfiguration sequencer (osc_300 domain).
// Optional macro MMCM_CTRL_LOCK_MON_EN adds lock_lost_cnt and automatic relock on lock loss in IDLE.
module mmcm_reconfig_ctrl #(
    parameter int RST_CYCLES   = 8,
    parameter int DRP_TIMEOUT  = 64,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  req_divide,
    output logic        done,
    output logic [1:0]  err_code,
    output logic        locked_sync,
`ifdef MMCM_CTRL_LOCK_MON_EN
    output logic [7:0]  lock_lost_cnt,
`endif
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic [6:0]  daddr,
    output logic [15:0] di,
    input  logic [15:0] dout,
    output logic        den,
    output logic        dwe,
    input  logic        drdy
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int DTW = $clog2(DRP_TIMEOUT + 1);
    localparam int LTW = $clog2(LOCK_TIMEOUT + 1);
    localparam int TW  = (LTW > DTW) ? LTW : DTW;

    localparam logic [6:0] ADDR_CLKREG1 = 7'h08;
    localparam logic [6:0] ADDR_CLKREG2 = 7'h09;

    localparam logic [3:0] BOOT_RST   = 4'd0;
    localparam logic [3:0] BOOT_LOCK  = 4'd1;
    localparam logic [3:0] IDLE       = 4'd2;
    localparam logic [3:0] ASSERT_RST = 4'd3;
    localparam logic [3:0] RD1        = 4'd4;
    localparam logic [3:0] W_RD1      = 4'd5;
    localparam logic [3:0] WR1        = 4'd6;
    localparam logic [3:0] W_WR1      = 4'd7;
    localparam logic [3:0] RD2        = 4'd8;
    localparam logic [3:0] W_RD2      = 4'd9;
    localparam logic [3:0] WR2        = 4'd10;
    localparam logic [3:0] W_WR2      = 4'd11;
    localparam logic [3:0] HOLD_RST   = 4'd12;
    localparam logic [3:0] WAIT_LOCK  = 4'd13;

    logic [3:0]     state;
    logic           lock_meta;
    logic [RCW-1:0] rst_cnt;
    logic           rst_done;
    logic [TW-1:0]  tmr;
    logic [6:0]     div_q;
    logic [15:0]    rd_data;
    logic [1:0]     pend_err;
    logic [5:0]     clk_high;
    logic [5:0]     clk_low;
    logic           clk_edge;
    logic           no_count;
    logic           lock_drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta   <= 1'b0;
            locked_sync <= 1'b0;
        end else begin
            lock_meta   <= mmcm_locked;
            locked_sync <= lock_meta;
        end
    end

    // Counts cycles mmcm_rst has been high; rst_done means it has been high RST_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (rst || !mmcm_rst) begin
            rst_cnt <= '0;
        end else if (!rst_done) begin
            rst_cnt <= rst_cnt + 1'b1;
        end
    end

    assign rst_done = (rst_cnt == RCW'(RST_CYCLES - 1));

`ifdef MMCM_CTRL_LOCK_MON_EN
    logic locked_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            locked_prev   <= 1'b0;
            lock_lost_cnt <= 8'd0;
        end else begin
            locked_prev <= locked_sync;
            if (lock_drop && lock_lost_cnt != 8'hFF) begin
                lock_lost_cnt <= lock_lost_cnt + 8'd1;
            end
        end
    end

    assign lock_drop = (state == IDLE) && locked_prev && !locked_sync;
`else
    assign lock_drop = 1'b0;
`endif

    assign req_ready = (state == IDLE) && !lock_drop;

    always_comb begin
        if (div_q == 7'd1) begin
            clk_high = 6'd1;
            clk_low  = 6'd1;
            clk_edge = 1'b0;
            no_count = 1'b1;
        end else begin
            clk_high = div_q[6:1];
            clk_low  = 6'(div_q - {1'b0, div_q[6:1]});
            clk_edge = div_q[0];
            no_count = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= BOOT_RST;
            mmcm_rst <= 1'b1;
            done     <= 1'b0;
            err_code <= 2'd0;
            den      <= 1'b0;
            dwe      <= 1'b0;
            daddr    <= 7'd0;
            di       <= 16'd0;
            div_q    <= 7'd0;
            rd_data  <= 16'd0;
            tmr      <= '0;
            pend_err <= 2'd0;
        end else begin
            done <= 1'b0;
            den  <= 1'b0;
            dwe  <= 1'b0;
            case (state)
                BOOT_RST: begin
                    if (rst_done) begin
                        mmcm_rst <= 1'b0;
                        state    <= BOOT_LOCK;
                    end
                end
                BOOT_LOCK: begin
                    if (locked_sync) state <= IDLE;
                end
                IDLE: begin
                    if (lock_drop) begin
                        mmcm_rst <= 1'b1;
                        state    <= BOOT_RST;
                    end else if (req_valid) begin
                        if (req_divide == 7'd0 || req_divide == 7'd127) begin
                            done     <= 1'b1;
                            err_code <= 2'd1;
                        end else begin
                            div_q    <= req_divide;
                            mmcm_rst <= 1'b1;
                            pend_err <= 2'd0;
                            state    <= ASSERT_RST;
                        end
                    end
                end
                ASSERT_RST: state <= RD1;
                RD1, RD2: begin
                    daddr <= (state == RD1) ? ADDR_CLKREG1 : ADDR_CLKREG2;
                    den   <= 1'b1;
                    tmr   <= '0;
                    state <= state + 4'd1;
                end
                WR1: begin
                    daddr <= ADDR_CLKREG1;
                    di    <= (rd_data & 16'h1000) | {4'd0, clk_high, clk_low};
                    den   <= 1'b1;
                    dwe   <= 1'b1;
                    tmr   <= '0;
                    state <= W_WR1;
                end
                WR2: begin
                    daddr <= ADDR_CLKREG2;
                    di    <= (rd_data & 16'hFF3F) | {8'd0, clk_edge, no_count, 6'd0};
                    den   <= 1'b1;
                    dwe   <= 1'b1;
                    tmr   <= '0;
                    state <= W_WR2;
                end
                // Legal path is encoded sequentially, so each wait state advances by one on drdy.
                W_RD1, W_WR1, W_RD2, W_WR2: begin
                    if (drdy) begin
                        if (state == W_RD1 || state == W_RD2) rd_data <= dout;
                        state <= state + 4'd1;
                    end else if (tmr == TW'(DRP_TIMEOUT - 1)) begin
                        pend_err <= 2'd2;
                        state    <= HOLD_RST;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                HOLD_RST: begin
                    if (rst_done) begin
                        mmcm_rst <= 1'b0;
                        tmr      <= '0;
                        state    <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    if (locked_sync) begin
                        done     <= 1'b1;
                        err_code <= pend_err;
                        state    <= IDLE;
                    end else if (tmr == TW'(LOCK_TIMEOUT - 1)) begin
                        done     <= 1'b1;
                        err_code <= 2'd3;
                        state    <= IDLE;
                    end else begin
                        tmr <= tmr + 1'b1;
                    end
                end
                default: begin
                    mmcm_rst <= 1'b1;
                    state    <= BOOT_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_reconfig_ctrl.sv
// Directed bench for mmcm_reconfig_ctrl: MMCM/DRP responder model, write and done-code scoreboards.
// Define MMCM_CTRL_LOCK_MON_EN to also exercise lock-loss relock.
module tb_mmcm_reconfig_ctrl;

    localparam int RST_CYCLES   = 8;
    localparam int DRP_TIMEOUT  = 64;
    localparam int LOCK_TIMEOUT = 100;
    localparam int LOCK_DELAY   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  req_divide = 7'd0;
    logic        done;
    logic [1:0]  err_code;
    logic        locked_sync;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;
    logic [6:0]  daddr;
    logic [15:0] di;
    logic [15:0] dout = 16'd0;
    logic        den;
    logic        dwe;
    logic        drdy = 1'b0;
`ifdef MMCM_CTRL_LOCK_MON_EN
    logic [7:0]  lock_lost_cnt;
`endif

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic        lock_en = 1'b1;
    logic        drdy_en = 1'b1;
    logic        force_unlock = 1'b0;
    logic [15:0] rd_val1 = 16'd0;
    logic [15:0] rd_val2 = 16'd0;
    int          lock_dly = 0;
    int          den_count = 0;
    int          done_count = 0;
    int          last_den_cyc = 0;
    logic        drp_pend = 1'b0;
    int          drp_wait = 0;
    logic [6:0]  drp_addr = 7'd0;
    logic [22:0] exp_wr;
    logic [1:0]  exp_err;
    logic [22:0] exp_wr_q[$];
    logic [1:0]  exp_err_q[$];

    mmcm_reconfig_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .DRP_TIMEOUT (DRP_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_divide (req_divide),
        .done       (done),
        .err_code   (err_code),
        .locked_sync(locked_sync),
`ifdef MMCM_CTRL_LOCK_MON_EN
        .lock_lost_cnt(lock_lost_cnt),
`endif
        .mmcm_rst   (mmcm_rst),
        .mmcm_locked(mmcm_locked),
        .daddr      (daddr),
        .di         (di),
        .dout       (dout),
        .den        (den),
        .dwe        (dwe),
        .drdy       (drdy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // MMCM model: locks LOCK_DELAY cycles after RST falls; DRP answers two cycles after den.
    always @(posedge clk) begin
        #2;
        if (mmcm_rst || !lock_en || force_unlock) begin
            mmcm_locked = 1'b0;
            lock_dly = 0;
        end else if (lock_dly < LOCK_DELAY) begin
            lock_dly++;
        end else begin
            mmcm_locked = 1'b1;
        end

        drdy = 1'b0;
        if (den) begin
            den_count++;
            last_den_cyc = cyc;
            checkOutput("den_under_mmcm_rst", 32'(mmcm_rst), 32'd1);
            if (dwe) begin
                if (exp_wr_q.size() == 0) begin
                    checkOutput("write_unexpected", {9'd0, daddr, di}, 32'd0);
                end else begin
                    exp_wr = exp_wr_q.pop_front();
                    checkOutput("drp_write", {9'd0, daddr, di}, {9'd0, exp_wr});
                end
            end
            if (drdy_en) begin
                drp_pend = 1'b1;
                drp_wait = 2;
                drp_addr = daddr;
            end
        end else if (drp_pend) begin
            drp_wait--;
            if (drp_wait == 0) begin
                drdy = 1'b1;
                dout = (drp_addr == 7'h09) ? rd_val2 : rd_val1;
                drp_pend = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (done) begin
            done_count++;
            if (exp_err_q.size() == 0) begin
                checkOutput("done_unexpected", 32'(done), 32'd0);
            end else begin
                exp_err = exp_err_q.pop_front();
                checkOutput("done_err_code", 32'(err_code), 32'(exp_err));
            end
        end
    end

    function automatic logic sigVal(input int which);
        case (which)
            0:       return mmcm_rst;
            1:       return done;
            2:       return req_ready;
            3:       return mmcm_locked;
            default: return den & dwe;
        endcase
    endfunction

    task automatic waitFor(input string tag, input int which, input logic level,
                           input int budget, output int cycles);
        cycles = 0;
        while (sigVal(which) !== level && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        if (sigVal(which) !== level) checkOutput(tag, 32'(sigVal(which)), 32'(level));
    endtask

    task automatic applyStimulus(input logic [6:0] div);
        bit taken = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_divide = div;
        for (int i = 0; i < 50 && !taken; i++) begin
            if (req_ready) begin
                @(posedge clk);
                #1;
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        checkOutput("req_accepted", 32'(taken), 32'd1);
    endtask

    task automatic bootSequence(input string tag);
        int n;
        int lat;
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput({tag, "_rst_mmcm_rst"}, 32'(mmcm_rst), 32'd1);
        checkOutput({tag, "_rst_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_rst_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_rst_err_code"}, 32'(err_code), 32'd0);
        checkOutput({tag, "_rst_den_dwe"}, {30'd0, den, dwe}, 32'd0);
        checkOutput({tag, "_rst_daddr_di"}, {9'd0, daddr, di}, 32'd0);
        checkOutput({tag, "_rst_locked_sync"}, 32'(locked_sync), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput({tag, "_mmcm_rst_len"}, 32'(n), 32'(RST_CYCLES));
        waitFor({tag, "_lock_timeout"}, 3, 1'b1, 200, lat);
        waitFor({tag, "_ready_timeout"}, 2, 1'b1, 10, lat);
        checkOutput({tag, "_ready_latency_le3"}, 32'(lat <= 3), 32'd1);
    endtask

    task automatic runRequest(input string tag, input logic [6:0] div, input logic [15:0] r1,
                              input logic [15:0] r2, input logic [15:0] w1, input logic [15:0] w2);
        int d0;
        int dc0;
        int n;
        rd_val1 = r1;
        rd_val2 = r2;
        exp_wr_q.push_back({7'h08, w1});
        exp_wr_q.push_back({7'h09, w2});
        exp_err_q.push_back(2'd0);
        d0  = den_count;
        dc0 = done_count;
        applyStimulus(div);
        @(negedge clk);
        waitFor({tag, "_done_timeout"}, 1, 1'b1, 500, n);
        @(negedge clk);
        checkOutput({tag, "_den_pulses"}, 32'(den_count - d0), 32'd4);
        checkOutput({tag, "_done_pulses"}, 32'(done_count - dc0), 32'd1);
    endtask

    initial begin
        int n;
        int d0;
        int dc0;
        int gap;

        $display("[TB] boot");
        bootSequence("boot");
        checkOutput("boot_no_done", 32'(done_count), 32'd0);

        $display("[TB] legal divides");
        runRequest("div60", 7'd60, 16'h1041, 16'h0000, 16'h179E, 16'h0000);
        runRequest("div1", 7'd1, 16'h0000, 16'h0000, 16'h0041, 16'h0040);
        runRequest("div2", 7'd2, 16'hFFFF, 16'hFFFF, 16'h1041, 16'hFF3F);
        runRequest("div126", 7'd126, 16'hFFFF, 16'h0000, 16'h1FFF, 16'h0000);

        $display("[TB] range errors");
        d0 = den_count;
        exp_err_q.push_back(2'd1);
        applyStimulus(7'd0);
        @(negedge clk);
        checkOutput("range0_done", 32'(done), 32'd1);
        checkOutput("range0_err", 32'(err_code), 32'd1);
        checkOutput("range0_mmcm_rst", 32'(mmcm_rst), 32'd0);
        repeat (4) @(negedge clk);
        exp_err_q.push_back(2'd1);
        applyStimulus(7'd127);
        @(negedge clk);
        checkOutput("range127_done", 32'(done), 32'd1);
        checkOutput("range127_err", 32'(err_code), 32'd1);
        checkOutput("range127_mmcm_rst", 32'(mmcm_rst), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("range_den_pulses", 32'(den_count - d0), 32'd0);

        $display("[TB] drdy timeout");
        drdy_en = 1'b0;
        d0 = den_count;
        exp_err_q.push_back(2'd2);
        applyStimulus(7'd60);
        @(negedge clk);
        waitFor("drp_to_release_timeout", 0, 1'b0, 300, n);
        gap = cyc - last_den_cyc;
        checkOutput("drp_to_gap_in_range", 32'(gap >= DRP_TIMEOUT && gap <= DRP_TIMEOUT + 4), 32'd1);
        checkOutput("drp_to_den_pulses", 32'(den_count - d0), 32'd1);
        waitFor("drp_to_done_timeout", 1, 1'b1, 200, n);
        @(negedge clk);
        drdy_en = 1'b1;

        $display("[TB] lock timeout");
        lock_en = 1'b0;
        rd_val1 = 16'h0000;
        rd_val2 = 16'hFFFF;
        exp_wr_q.push_back({7'h08, 16'h00C4});
        exp_wr_q.push_back({7'h09, 16'hFFBF});
        exp_err_q.push_back(2'd3);
        applyStimulus(7'd7);
        @(negedge clk);
        waitFor("lock_to_release_timeout", 0, 1'b0, 300, n);
        waitFor("lock_to_done_timeout", 1, 1'b1, LOCK_TIMEOUT + 20, n);
        checkOutput("lock_to_latency", 32'(n), 32'(LOCK_TIMEOUT));
        @(negedge clk);
        checkOutput("lock_to_mmcm_rst", 32'(mmcm_rst), 32'd0);
        checkOutput("lock_to_ready", 32'(req_ready), 32'd1);
        lock_en = 1'b1;
        waitFor("relock_idle_timeout", 3, 1'b1, 100, n);
        repeat (4) @(negedge clk);

        $display("[TB] reset during W_WR1");
        rd_val1 = 16'h1041;
        rd_val2 = 16'h0000;
        exp_wr_q.push_back({7'h08, 16'h179E});
        exp_err_q.push_back(2'd0);
        dc0 = done_count;
        applyStimulus(7'd60);
        @(negedge clk);
        waitFor("abort_wr1_timeout", 4, 1'b1, 100, n);
        checkOutput("abort_wr1_seen", 32'(exp_wr_q.size()), 32'd0);
        exp_wr_q.delete();
        exp_err_q.delete();
        bootSequence("reboot");
        repeat (10) @(negedge clk);
        checkOutput("abort_no_done", 32'(done_count - dc0), 32'd0);

`ifdef MMCM_CTRL_LOCK_MON_EN
        $display("[TB] lock loss in IDLE");
        d0  = den_count;
        dc0 = done_count;
        checkOutput("lock_lost_cnt_zero", 32'(lock_lost_cnt), 32'd0);
        force_unlock = 1'b1;
        waitFor("lockmon_rst_timeout", 0, 1'b1, 20, n);
        force_unlock = 1'b0;
        n = 0;
        while (mmcm_rst === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("lockmon_rst_len", 32'(n), 32'(RST_CYCLES));
        checkOutput("lock_lost_cnt_one", 32'(lock_lost_cnt), 32'd1);
        waitFor("lockmon_ready_timeout", 2, 1'b1, 200, n);
        checkOutput("lockmon_no_den", 32'(den_count - d0), 32'd0);
        checkOutput("lockmon_no_done", 32'(done_count - dc0), 32'd0);
`endif

        checkOutput("write_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        checkOutput("done_queue_empty", 32'(exp_err_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
